// File: rtl/regfile_scoreboard_if.sv
// Decode-stage bus between the instruction decoder and the register file.
// Carries read/write ports, clear control and scoreboard/stall status.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clear_req;
    logic              clear_busy;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_used;
    logic              rt_used;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              equal;
    logic              not_equal;
    logic              reg_write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              pend_set_en;
    logic [ADDR_W-1:0] pend_set_addr;
    logic              rs_pending;
    logic              rt_pending;
    logic              stall;

    modport master (
        output clear_req, rs_addr, rt_addr, rs_used, rt_used,
               reg_write_en, write_addr, write_data, pend_set_en, pend_set_addr,
        input  clear_busy, read_data_1, read_data_2, equal, not_equal,
               rs_pending, rt_pending, stall
    );

    modport slave (
        input  clear_req, rs_addr, rt_addr, rs_used, rt_used,
               reg_write_en, write_addr, write_data, pend_set_en, pend_set_addr,
        output clear_busy, read_data_1, read_data_2, equal, not_equal,
               rs_pending, rt_pending, stall
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with write-to-read bypass, branch compare, pending-write
// scoreboard and a sweep FSM that zeroes the array after reset or on request.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] next_ptr;
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  next_pend;
    logic [DATA_W-1:0] regs [DEPTH];

    logic              busy;
    logic              clear_pend;
    logic              write_ok;
    logic              set_ok;
    logic              hit_1;
    logic              hit_2;
    logic [DATA_W-1:0] data_1;
    logic [DATA_W-1:0] data_2;
    logic [DATA_W-1:0] rd_1;
    logic [DATA_W-1:0] rd_2;
    logic              pending_1;
    logic              pending_2;

    assign busy     = (state == CLEAR);
    assign write_ok = !busy && bus.reg_write_en &&
                      !((ZERO_REG != 0) && (bus.write_addr == '0));
    assign set_ok   = !busy && bus.pend_set_en &&
                      !((ZERO_REG != 0) && (bus.pend_set_addr == '0));
    assign hit_1    = (BYPASS != 0) && write_ok && (bus.write_addr == bus.rs_addr);
    assign hit_2    = (BYPASS != 0) && write_ok && (bus.write_addr == bus.rt_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
            ptr   <= '0;
            pend  <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
            pend  <= next_pend;
        end
    end

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        clear_pend = 1'b0;
        case (state)
            CLEAR: begin
                next_ptr = ptr + 1'b1;
                if (ptr == LAST_ADDR) next_state = IDLE;
            end
            IDLE: begin
                if (bus.clear_req) begin
                    next_state = CLEAR;
                    next_ptr   = '0;
                    clear_pend = 1'b1;
                end
            end
        endcase
    end

    // Set is applied after the write-back clear so a same-address collision stays pending.
    always_comb begin
        next_pend = pend;
        if (clear_pend) begin
            next_pend = '0;
        end else begin
            if (write_ok) next_pend[bus.write_addr]    = 1'b0;
            if (set_ok)   next_pend[bus.pend_set_addr] = 1'b1;
        end
    end

    // No reset on the array so it can map to LUT-RAM; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (busy) begin
            regs[ptr] <= '0;
        end else if (write_ok) begin
            regs[bus.write_addr] <= bus.write_data;
        end
    end

    always_comb begin
        data_1 = regs[bus.rs_addr];
        data_2 = regs[bus.rt_addr];
        if ((ZERO_REG != 0) && (bus.rs_addr == '0)) data_1 = '0;
        else if (hit_1)                             data_1 = bus.write_data;
        if ((ZERO_REG != 0) && (bus.rt_addr == '0)) data_2 = '0;
        else if (hit_2)                             data_2 = bus.write_data;
    end

    assign rd_1      = busy ? '0 : data_1;
    assign rd_2      = busy ? '0 : data_2;
    assign pending_1 = !busy && pend[bus.rs_addr] && !hit_1;
    assign pending_2 = !busy && pend[bus.rt_addr] && !hit_2;

    assign bus.clear_busy  = busy;
    assign bus.read_data_1 = rd_1;
    assign bus.read_data_2 = rd_2;
    assign bus.equal       = (rd_1 == rd_2);
    assign bus.not_equal   = (rd_1 != rd_2);
    assign bus.rs_pending  = pending_1;
    assign bus.rt_pending  = pending_2;
    assign bus.stall       = busy || (bus.rs_used && pending_1) || (bus.rt_used && pending_2);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: a reference model predicts each cycle's outputs for a
// bypassing and a non-bypassing instance; a negedge monitor compares them.
module tb_regfile_scoreboard;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef struct {
        logic        rst_n;
        logic        clear_req;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rs_used;
        logic        rt_used;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        set;
        logic [4:0]  sa;
    } stim_t;

    typedef struct {
        logic        busy;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        eq;
        logic        rs_p;
        logic        rt_p;
        logic        stall;
        logic [31:0] nb_rd1;
        logic [31:0] nb_rd2;
        logic        nb_stall;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_nb ();

    regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .bus(bus_nb)
    );

    assign bus_nb.clear_req     = bus.clear_req;
    assign bus_nb.rs_addr       = bus.rs_addr;
    assign bus_nb.rt_addr       = bus.rt_addr;
    assign bus_nb.rs_used       = bus.rs_used;
    assign bus_nb.rt_used       = bus.rt_used;
    assign bus_nb.reg_write_en  = bus.reg_write_en;
    assign bus_nb.write_addr    = bus.write_addr;
    assign bus_nb.write_data    = bus.write_data;
    assign bus_nb.pend_set_en   = bus.pend_set_en;
    assign bus_nb.pend_set_addr = bus.pend_set_addr;

    logic [31:0] m_regs [DEPTH];
    bit          m_pend [DEPTH];
    int          busy_left;
    stim_t       prev;
    exp_t        exp_q [$];
    int          checks = 0;
    int          failures = 0;

    function automatic stim_t quiet();
        stim_t s;
        s.rst_n = 1'b1; s.clear_req = 1'b0;
        s.rs = '0; s.rt = '0; s.rs_used = 1'b0; s.rt_used = 1'b0;
        s.we = 1'b0; s.wa = '0; s.wd = '0; s.set = 1'b0; s.sa = '0;
        return s;
    endfunction

    // A sweep leaves every register zero and nothing pending; reads are forced
    // to zero while it runs, so the model simply empties itself when one starts.
    task automatic model_start_sweep();
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input stim_t s);
        if (!s.rst_n) return;
        if (busy_left > 0) begin
            busy_left--;
        end else if (s.clear_req) begin
            model_start_sweep();
        end else begin
            if (s.we && s.wa != 0) begin
                m_regs[s.wa] = s.wd;
                m_pend[s.wa] = 1'b0;
            end
            if (s.set && s.sa != 0) m_pend[s.sa] = 1'b1;
        end
    endtask

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        logic hit1, hit2;
        e.busy = (busy_left > 0) || !s.rst_n;
        if (e.busy) begin
            e.rd1 = '0; e.rd2 = '0; e.eq = 1'b1; e.rs_p = 1'b0; e.rt_p = 1'b0;
            e.stall = 1'b1; e.nb_rd1 = '0; e.nb_rd2 = '0; e.nb_stall = 1'b1;
        end else begin
            hit1 = s.we && (s.wa != 0) && (s.wa == s.rs);
            hit2 = s.we && (s.wa != 0) && (s.wa == s.rt);
            e.rd1    = (s.rs == 0) ? 32'h0 : (hit1 ? s.wd : m_regs[s.rs]);
            e.rd2    = (s.rt == 0) ? 32'h0 : (hit2 ? s.wd : m_regs[s.rt]);
            e.nb_rd1 = (s.rs == 0) ? 32'h0 : m_regs[s.rs];
            e.nb_rd2 = (s.rt == 0) ? 32'h0 : m_regs[s.rt];
            e.eq     = (e.rd1 == e.rd2);
            e.rs_p   = m_pend[s.rs] && !hit1;
            e.rt_p   = m_pend[s.rt] && !hit2;
            e.stall  = (s.rs_used && e.rs_p) || (s.rt_used && e.rt_p);
            e.nb_stall = (s.rs_used && m_pend[s.rs]) || (s.rt_used && m_pend[s.rt]);
        end
        return e;
    endfunction

    task automatic apply_stimulus(input stim_t s);
        @(posedge clk);
        model_edge(prev);
        #1;
        reset             = s.rst_n;
        bus.clear_req     = s.clear_req;
        bus.rs_addr       = s.rs;
        bus.rt_addr       = s.rt;
        bus.rs_used       = s.rs_used;
        bus.rt_used       = s.rt_used;
        bus.reg_write_en  = s.we;
        bus.write_addr    = s.wa;
        bus.write_data    = s.wd;
        bus.pend_set_en   = s.set;
        bus.pend_set_addr = s.sa;
        if (!s.rst_n) model_start_sweep();
        prev = s;
        exp_q.push_back(predict(s));
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output(input exp_t e);
        check_val("clear_busy",     32'(bus.clear_busy),  32'(e.busy));
        check_val("read_data_1",    bus.read_data_1,      e.rd1);
        check_val("read_data_2",    bus.read_data_2,      e.rd2);
        check_val("equal",          32'(bus.equal),       32'(e.eq));
        check_val("not_equal",      32'(bus.not_equal),   32'(!e.eq));
        check_val("rs_pending",     32'(bus.rs_pending),  32'(e.rs_p));
        check_val("rt_pending",     32'(bus.rt_pending),  32'(e.rt_p));
        check_val("stall",          32'(bus.stall),       32'(e.stall));
        check_val("nb_read_data_1", bus_nb.read_data_1,   e.nb_rd1);
        check_val("nb_read_data_2", bus_nb.read_data_2,   e.nb_rd2);
        check_val("nb_stall",       32'(bus_nb.stall),    32'(e.nb_stall));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        stim_t s;
        s = quiet(); s.we = 1'b1; s.wa = a; s.wd = d;
        apply_stimulus(s);
    endtask

    initial begin
        stim_t s;
        bus.clear_req = 1'b0; bus.rs_addr = '0; bus.rt_addr = '0;
        bus.rs_used = 1'b0; bus.rt_used = 1'b0; bus.reg_write_en = 1'b0;
        bus.write_addr = '0; bus.write_data = '0; bus.pend_set_en = 1'b0;
        bus.pend_set_addr = '0;
        prev = quiet(); prev.rst_n = 1'b0;
        model_start_sweep();

        // Reset, then the power-on sweep and a read of every address.
        s = quiet(); s.rst_n = 1'b0;
        repeat (3) apply_stimulus(s);
        s = quiet();
        repeat (34) apply_stimulus(s);
        for (int i = 0; i < DEPTH; i++) begin
            s = quiet(); s.rs = 5'(i); s.rt = 5'(31 - i); s.rs_used = 1'b1; s.rt_used = 1'b1;
            apply_stimulus(s);
        end

        // Same-cycle bypass of a write to r5.
        s = quiet(); s.we = 1'b1; s.wa = 5'd5; s.wd = 32'hDEADBEEF; s.rs = 5'd5;
        apply_stimulus(s);
        s = quiet(); s.rs = 5'd5;
        apply_stimulus(s);

        // Register 0 ignores writes and pending marks.
        s = quiet(); s.we = 1'b1; s.wa = 5'd0; s.wd = 32'h1234; s.set = 1'b1; s.sa = 5'd0;
        s.rs = 5'd0; s.rs_used = 1'b1;
        apply_stimulus(s);
        s = quiet(); s.rs = 5'd0; s.rs_used = 1'b1;
        apply_stimulus(s);

        // Branch compare, including a bypassed change on port 2.
        write_reg(5'd3, 32'd7);
        write_reg(5'd4, 32'd7);
        s = quiet(); s.rs = 5'd3; s.rt = 5'd4;
        apply_stimulus(s);
        s.we = 1'b1; s.wa = 5'd4; s.wd = 32'd8;
        apply_stimulus(s);
        s = quiet(); s.rs = 5'd3; s.rt = 5'd4;
        apply_stimulus(s);

        // Scoreboard stall on r9, released by its write-back.
        s = quiet(); s.set = 1'b1; s.sa = 5'd9;
        apply_stimulus(s);
        s = quiet(); s.rs = 5'd9; s.rs_used = 1'b1;
        apply_stimulus(s);
        s.rs_used = 1'b0;
        apply_stimulus(s);
        s = quiet(); s.rs = 5'd9; s.rs_used = 1'b1; s.we = 1'b1; s.wa = 5'd9; s.wd = 32'h99;
        apply_stimulus(s);
        s = quiet(); s.rs = 5'd9; s.rs_used = 1'b1;
        apply_stimulus(s);

        // Set and write-back of r9 on one edge: it must remain pending.
        s = quiet(); s.set = 1'b1; s.sa = 5'd9; s.we = 1'b1; s.wa = 5'd9; s.wd = 32'h55;
        apply_stimulus(s);
        s = quiet(); s.rs = 5'd9; s.rt = 5'd9; s.rs_used = 1'b1; s.rt_used = 1'b1;
        apply_stimulus(s);

        // Clear request from idle, with a second request mid-sweep.
        s = quiet(); s.clear_req = 1'b1;
        apply_stimulus(s);
        s = quiet(); s.rs = 5'd9; s.rs_used = 1'b1;
        repeat (10) apply_stimulus(s);
        s.clear_req = 1'b1;
        apply_stimulus(s);
        s.clear_req = 1'b0;
        repeat (25) apply_stimulus(s);

        // Reset in the middle of a requested sweep.
        s = quiet(); s.clear_req = 1'b1;
        apply_stimulus(s);
        s = quiet();
        repeat (10) apply_stimulus(s);
        s.rst_n = 1'b0;
        repeat (2) apply_stimulus(s);
        s = quiet();
        repeat (34) apply_stimulus(s);

        // Random traffic on a narrowed address range to force collisions.
        for (int n = 0; n < 3000; n++) begin
            s.rst_n     = ($urandom_range(0, 399) != 0);
            s.clear_req = ($urandom_range(0, 99) == 0);
            s.rs        = 5'($urandom_range(0, 15));
            s.rt        = 5'($urandom_range(0, 15));
            s.rs_used   = 1'($urandom_range(0, 1));
            s.rt_used   = 1'($urandom_range(0, 1));
            s.we        = 1'($urandom_range(0, 1));
            s.wa        = 5'($urandom_range(0, 15));
            s.wd        = $urandom;
            s.set       = ($urandom_range(0, 2) == 0);
            s.sa        = 5'($urandom_range(0, 15));
            apply_stimulus(s);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain actual=%0d expected=0 entries left", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core register file: DEPTH x DATA_W storage, two combinational read ports, one write port.
- Adds write-to-read bypass, a branch compare (equal/not_equal) on the bypassed operands, and a per-register pending-write scoreboard that drives a stall output.
- Storage is cleared by an internal sweep FSM rather than a bulk reset, so the array can map to LUT-RAM.
- Sits in the decode stage between the instruction decoder and the ALU/branch unit.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W.
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never pending.
- BYPASS, 1, when 1, same-cycle write data is forwarded to read ports.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- clear_req  in  1  pulse: request a full array clear.
- clear_busy  out  1  sweep in progress.
- rs_addr  in  ADDR_W  read port 1 address.
- rt_addr  in  ADDR_W  read port 2 address.
- rs_used  in  1  port 1 operand is needed this cycle.
- rt_used  in  1  port 2 operand is needed this cycle.
- read_data_1  out  DATA_W  port 1 data.
- read_data_2  out  DATA_W  port 2 data.
- equal  out  1  read_data_1 == read_data_2.
- not_equal  out  1  inverse of equal.
- reg_write_en  in  1  write strobe.
- write_addr  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- pend_set_en  in  1  mark a register as awaiting a write-back.
- pend_set_addr  in  ADDR_W  register to mark.
- rs_pending  out  1  port 1 operand has an outstanding writer.
- rt_pending  out  1  port 2 operand has an outstanding writer.
- stall  out  1  decode must hold.

Behaviour:

Reset (reset=0, asynchronous):
- FSM forced to CLEAR; sweep pointer = 0.
- All pending bits = 0; clear_busy = 1; stall = 1.
- Storage contents are not reset.

FSM, two states:
- CLEAR: each edge writes 0 to regs[ptr] and increments ptr. At ptr = DEPTH-1 it writes that entry and moves to IDLE. Duration is exactly DEPTH cycles after reset deasserts.
- IDLE: clear_req=1 at an edge moves to CLEAR with ptr=0 and clears all pending bits on that same edge. In CLEAR, clear_req is ignored; the sweep does not restart.

While clear_busy=1:
- read_data_1/2 = 0; equal = 1; rs/rt_pending = 0; stall = 1.
- reg_write_en and pend_set_en are ignored.

Write (IDLE):
- reg_write_en=1 writes regs[write_addr] at the edge.
- Suppressed for write_addr=0 when ZERO_REG=1.
- The same edge clears pend[write_addr].

Read (combinational, IDLE):
- If ZERO_REG and addr=0: data is 0.
- Else, if BYPASS, reg_write_en, write_addr==addr, and the write is not suppressed: data is write_data.
- Else: data is regs[addr].

Compare:
- equal/not_equal are computed on the final (bypassed) read_data values.

Scoreboard:
- pend_set_en=1 sets pend[pend_set_addr] at the edge. Ignored for addr 0 when ZERO_REG=1.
- Simultaneous set and write-clear of the same address: set wins, pending stays 1.
- Setting an already-pending bit: stays 1, no counting.

Pending outputs:
- rs_pending = pend[rs_addr] AND NOT(bypass hit on port 1). rt_pending is the same for port 2.
- When BYPASS=0, the bypass term is 0.

Stall:
- stall = clear_busy OR (rs_used AND rs_pending) OR (rt_used AND rt_pending).

Reset mid-sweep:
- Restarts the sweep from ptr 0 after deassertion.

Latency:
- Reads, compare, pending and stall are all combinational.
- Writes and pending updates are visible after 1 edge, or in the same cycle through bypass.

Test Plan:
- Sweep: release reset with defaults -> clear_busy=1 for exactly 32 cycles, then 0. Every address then reads 0 and stall=0.
- Write/read/bypass: write 0xDEADBEEF to r5 while rs_addr=5 -> read_data_1=0xDEADBEEF in the same cycle. With BYPASS=0 the old value shows that cycle and the new value on the next cycle.
- Zero register: write 0x1234 to r0 and pend_set r0 -> r0 reads 0 and rs_pending stays 0.
- Compare: r3=r4=7 gives equal=1 and not_equal=0. Writing r4=8 with rt_addr=4 in the same cycle gives equal=0 immediately.
- Scoreboard: pend_set r9, then rs_addr=9 with rs_used=1 -> stall=1. Same with rs_used=0 -> stall=0. Write r9 -> stall drops in the write cycle (bypass) and stays 0 afterwards.
- Set/clear collision and clear request: pend_set r9 and write r9 on the same edge -> r9 stays pending. clear_req from IDLE -> all pending bits clear and the sweep runs 32 cycles. A second clear_req mid-sweep leaves the duration unchanged. reset=0 mid-sweep restarts it at ptr 0.
